scanline_scheduler: RTL and testbench
=====================================

# scanline_scheduler

Per-triangle scanline sequencer that drives the colorfill stage. It accepts one triangle at a time from the rasterizer front end and computes the triangle's screen-clipped vertical span. It then issues one fill request per scanline to colorfill and waits for colorfill's `data_ready` before advancing. A watchdog aborts a triangle if colorfill stops responding.

## Interface
Parameters:
- `SCREEN_H`, default 480: number of scanlines; valid heights are 0..SCREEN_H-1.
- `TIMEOUT`, default 4096: maximum cycles to wait for `fill_done` on one line.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `tri_valid`  in  1  upstream triangle available.
- `tri_in`  in  Triangle3D  triangle; only the three vertex y fields are used for span computation.
- `tri_color`  in  Color  fill colour for the triangle.
- `tri_ready`  out  1  scheduler can accept a triangle; high only in IDLE.
- `fill_en`  out  1  one-cycle request to colorfill; connects to its `color_en`.
- `fill_height`  out  shortint  current scanline; connects to colorfill `height`.
- `fill_tri`  out  Triangle3D  latched triangle; connects to colorfill `ver`.
- `fill_color`  out  Color  latched colour; connects to colorfill `rgb_val`.
- `fill_done`  in  1  colorfill `data_ready`.
- `busy`  out  1  high in every state except IDLE.
- `tri_done`  out  1  one-cycle pulse when a triangle finishes, whether completed or aborted.
- `tri_count`  out  16  number of triangles finished; wraps modulo 2^16.
- `timeout_err`  out  1  sticky watchdog flag.
- `clear_err`  in  1  clears `timeout_err`.

## Operation
- Handshake: a triangle is accepted when `tri_valid && tri_ready`. On acceptance, `tri_in` and `tri_color` are latched into `fill_tri` and `fill_color`.
- States:
  - IDLE: wait for a triangle, then go to SETUP.
  - SETUP: register the clipped span.
    - `ymin = max(min(y0,y1,y2), 0)`.
    - `ymax = min(max(y0,y1,y2), SCREEN_H-1)`.
    - All comparisons are signed 16-bit.
    - Load `cur_y = ymin`.
    - If `ymin > ymax`, the triangle is fully off-screen: go to DONE and issue no lines. Otherwise go to ISSUE.
  - ISSUE: `fill_en = 1`, clear the watchdog, go to WAIT_LINE.
  - WAIT_LINE: wait for `fill_done`. When it arrives, go to NEXT. If the watchdog reaches `TIMEOUT-1` first, set `timeout_err` and go to DONE (abort).
  - NEXT: if `cur_y == ymax`, go to DONE. Otherwise increment `cur_y` and go to ISSUE.
  - DONE: pulse `tri_done`, increment `tri_count`, go to IDLE.
- Lines are issued in ascending order, `ymin` through `ymax` inclusive. A triangle whose three y values are equal produces exactly one line.
- `fill_height`, `fill_tri` and `fill_color` are held stable from ISSUE until the line's `fill_done`, because colorfill reads them combinationally throughout its fill.
- `fill_done` seen in any state other than WAIT_LINE is ignored.
- If `timeout_err` setting and `clear_err` occur in the same cycle, setting wins.

## Timing
- Reset values:
  - `tri_ready` = 1 (IDLE).
  - `fill_en`, `busy`, `tri_done`, `timeout_err` = 0.
  - `fill_height`, `tri_count` = 0.
  - `fill_tri`, `fill_color` = all zero.
- Accept at cycle T:
  - SETUP at T+1.
  - First `fill_en` at T+2.
- `fill_done` at cycle F: NEXT at F+1, next `fill_en` at F+2. This gives colorfill its DONE-to-IDLE cycle before the next request.
- Per-line overhead is 3 cycles plus colorfill latency.
- Off-screen triangle: `tri_done` at T+2, with no `fill_en`.
- `tri_ready` is low from T+1 until the cycle after `tri_done`. Maximum acceptance rate is one triangle per `(lines × (colorfill latency + 3)) + 3` cycles.
- Reset mid-operation returns the block to IDLE immediately and drops the in-flight line. Colorfill shares the same reset tree, so the two stay consistent.

## Structure
- Shared package (`defines_package.vh`):
  - `HEIGHT` define, used as the default for `SCREEN_H`.
  - Triangle3D, Color and Point2D stay in the package unchanged.
- The state enum is local to the module.
- Sub-module `y_span_clip`: combinational min/max of three signed y values plus clipping to 0..SCREEN_H-1. It also produces the `empty` flag (`ymin > ymax`).

## Test plan
- Triangle with y = {10, 12, 11} and a colorfill model with 20-cycle latency: exactly 3 `fill_en` pulses, at heights 10, 11, 12. Then one `tri_done`, and `tri_count` = 1.
- Triangle with y = {-5, -1, -3}: no `fill_en`, `tri_done` at T+2. Triangle with y = {470, 500, 490}: heights 470..479 only.
- All three y = 100: exactly one `fill_en`, at height 100.
- Model never asserts `fill_done`, with `TIMEOUT` = 16: `timeout_err` rises 16 cycles after `fill_en`, then `tri_done` pulses. Assert `clear_err` together with a second timeout: the flag stays 1.
- Back-to-back `tri_valid` with two triangles: the second is accepted only the cycle after the first `tri_done`. `fill_tri` stays unchanged while a line is pending.
- Assert `rst` during WAIT_LINE: outputs return to their reset values asynchronously, and the next triangle is processed normally.

Source files
------------

// File: rtl/scanline_scheduler_pkg.sv
// Shared geometry/colour types and screen constants for the raster pipeline.
// Pure declarations: no latency, no flow control.
package scanline_scheduler_pkg;

    localparam int HEIGHT = 480;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
    } Point2D;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } Point3D;

    typedef struct packed {
        Point3D v0;
        Point3D v1;
        Point3D v2;
    } Triangle3D;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } Color;

    function automatic logic signed [15:0] smin(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scanline_scheduler_if.sv
// Bundle of the triangle intake handshake, colorfill request bus and status lines.
// Wiring only: no latency; intake is valid/ready, colorfill is request/done.
interface scanline_scheduler_if;
    import scanline_scheduler_pkg::*;

    logic               tri_valid;
    Triangle3D          tri_in;
    Color               tri_color;
    logic               tri_ready;

    logic               fill_en;
    logic signed [15:0] fill_height;
    Triangle3D          fill_tri;
    Color               fill_color;
    logic               fill_done;

    logic               busy;
    logic               tri_done;
    logic [15:0]        tri_count;
    logic               timeout_err;
    logic               clear_err;

    modport master (
        input  tri_valid, tri_in, tri_color, fill_done, clear_err,
        output tri_ready, fill_en, fill_height, fill_tri, fill_color,
               busy, tri_done, tri_count, timeout_err
    );

    modport slave (
        output tri_valid, tri_in, tri_color, fill_done, clear_err,
        input  tri_ready, fill_en, fill_height, fill_tri, fill_color,
               busy, tri_done, tri_count, timeout_err
    );

endinterface

// File: rtl/scanline_scheduler_y_span_clip.sv
// Signed min/max of three vertex heights clipped to the visible rows 0..SCREEN_H-1.
// Purely combinational; empty_o flags a span that lies entirely off screen.
module scanline_scheduler_y_span_clip
    import scanline_scheduler_pkg::*;
#(
    parameter int SCREEN_H = HEIGHT
) (
    input  logic signed [15:0] y0_i,
    input  logic signed [15:0] y1_i,
    input  logic signed [15:0] y2_i,
    output logic signed [15:0] ymin_o,
    output logic signed [15:0] ymax_o,
    output logic               empty_o
);
    localparam logic signed [15:0] YTOP = 16'(SCREEN_H - 1);

    logic signed [15:0] lo;
    logic signed [15:0] hi;

    always_comb begin
        lo      = smin(smin(y0_i, y1_i), y2_i);
        hi      = smax(smax(y0_i, y1_i), y2_i);
        ymin_o  = smax(lo, 16'sd0);
        ymax_o  = smin(hi, YTOP);
        empty_o = (ymin_o > ymax_o);
    end

endmodule

// File: rtl/scanline_scheduler.sv
// Per-triangle scanline sequencer feeding colorfill one line at a time, with a per-line watchdog.
// First request 2 cycles after accept, next 2 cycles after each fill_done; tri_ready only in IDLE.
module scanline_scheduler
    import scanline_scheduler_pkg::*;
#(
    parameter int SCREEN_H = HEIGHT,
    parameter int TIMEOUT  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    scanline_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT_LINE,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t             state_q;
    logic signed [15:0] cur_y_q;
    logic signed [15:0] ymax_q;
    logic [WD_W-1:0]    wd_q;
    Triangle3D          fill_tri_q;
    Color               fill_color_q;
    logic               fill_en_q;
    logic               tri_ready_q;
    logic               busy_q;
    logic               tri_done_q;
    logic               timeout_err_q;
    logic [15:0]        tri_count_q;

    logic signed [15:0] cur_y_d;
    logic [15:0]        tri_count_d;
    logic [WD_W-1:0]    wd_d;

    logic signed [15:0] span_min;
    logic signed [15:0] span_max;
    logic               span_empty;

    scanline_scheduler_y_span_clip #(
        .SCREEN_H (SCREEN_H)
    ) u_span (
        .y0_i    (fill_tri_q.v0.y),
        .y1_i    (fill_tri_q.v1.y),
        .y2_i    (fill_tri_q.v2.y),
        .ymin_o  (span_min),
        .ymax_o  (span_max),
        .empty_o (span_empty)
    );

    assign cur_y_d     = cur_y_q + 16'sd1;
    assign tri_count_d = tri_count_q + 16'd1;
    assign wd_d        = wd_q + WD_W'(1);

    // The watchdog counts from the ISSUE cycle, so the abort lands exactly TIMEOUT cycles after fill_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cur_y_q       <= '0;
            ymax_q        <= '0;
            wd_q          <= '0;
            fill_tri_q    <= '0;
            fill_color_q  <= '0;
            fill_en_q     <= 1'b0;
            tri_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            tri_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            tri_count_q   <= '0;
        end else begin
            fill_en_q  <= 1'b0;
            tri_done_q <= 1'b0;
            if (bus.clear_err) begin
                timeout_err_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.tri_valid) begin
                        fill_tri_q   <= bus.tri_in;
                        fill_color_q <= bus.tri_color;
                        tri_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    cur_y_q <= span_min;
                    ymax_q  <= span_max;
                    if (span_empty) begin
                        tri_done_q  <= 1'b1;
                        tri_count_q <= tri_count_d;
                        state_q     <= S_DONE;
                    end else begin
                        fill_en_q <= 1'b1;
                        wd_q      <= '0;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_q    <= wd_d;
                    state_q <= S_WAIT_LINE;
                end
                S_WAIT_LINE: begin
                    if (bus.fill_done) begin
                        state_q <= S_NEXT;
                    end else if (wd_q == WD_LAST) begin
                        timeout_err_q <= 1'b1;
                        tri_done_q    <= 1'b1;
                        tri_count_q   <= tri_count_d;
                        state_q       <= S_DONE;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                S_NEXT: begin
                    if (cur_y_q == ymax_q) begin
                        tri_done_q  <= 1'b1;
                        tri_count_q <= tri_count_d;
                        state_q     <= S_DONE;
                    end else begin
                        cur_y_q   <= cur_y_d;
                        fill_en_q <= 1'b1;
                        wd_q      <= '0;
                        state_q   <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    tri_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    tri_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tri_ready   = tri_ready_q;
    assign bus.fill_en     = fill_en_q;
    assign bus.fill_height = cur_y_q;
    assign bus.fill_tri    = fill_tri_q;
    assign bus.fill_color  = fill_color_q;
    assign bus.busy        = busy_q;
    assign bus.tri_done    = tri_done_q;
    assign bus.tri_count   = tri_count_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_scanline_scheduler.sv
// Scoreboard bench: a 20-cycle colorfill model on the main instance, a silent colorfill on a TIMEOUT=16 instance.
module tb_scanline_scheduler;
    import scanline_scheduler_pkg::*;

    localparam int SCR = 480;
    localparam int LAT = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scanline_scheduler_if bus ();
    scanline_scheduler_if wbus ();

    scanline_scheduler #(.SCREEN_H(SCR), .TIMEOUT(4096)) dut    (.clk(clk), .rst(rst), .bus(bus));
    scanline_scheduler #(.SCREEN_H(SCR), .TIMEOUT(16))   dut_wd (.clk(clk), .rst(rst), .bus(wbus));

    typedef struct {
        int        h;
        Triangle3D t;
        Color      c;
        int        cyc;
    } line_t;

    typedef struct {
        int cnt;
        int cyc;
    } done_t;

    line_t exp_lines[$];
    done_t exp_done[$];
    int    exp_count = 0;
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    last_done_cyc = -1;
    bit    pending = 1'b0;
    line_t pend;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [143:0] got, input logic [143:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tri_ready"}, bus.tri_ready, 1);
        chk({tag, "_fill_en"}, bus.fill_en, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_tri_done"}, bus.tri_done, 0);
        chk({tag, "_timeout_err"}, bus.timeout_err, 0);
        chk({tag, "_fill_height"}, bus.fill_height, 0);
        chk({tag, "_tri_count"}, bus.tri_count, 0);
        chk({tag, "_fill_tri"}, bus.fill_tri, 0);
        chk({tag, "_fill_color"}, bus.fill_color, 0);
        chk({tag, "_wd_timeout_err"}, wbus.timeout_err, 0);
    endtask

    function automatic Triangle3D mk_tri(input int y0, input int y1, input int y2);
        Triangle3D t;
        t = '0;
        t.v0.y = 16'(y0); t.v1.y = 16'(y1); t.v2.y = 16'(y2);
        t.v0.x = 16'(y0 + 7); t.v1.x = 16'(y1 + 9); t.v2.x = 16'(y2 + 11);
        t.v0.z = 16'(3); t.v1.z = 16'(5); t.v2.z = 16'(-2);
        return t;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the acceptance edge.
    task automatic send(input int y0, input int y1, input int y2, input Color c, output int t_acc);
        Triangle3D t;
        int n, lo, hi;
        line_t l;
        done_t d;
        t = mk_tri(y0, y1, y2);
        bus.tri_valid = 1'b1;
        bus.tri_in    = t;
        bus.tri_color = c;
        n = 0;
        while (bus.tri_ready !== 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) chk("accept_wait_expired", 0, 1);
        t_acc = cyc;
        @(posedge clk); #1;
        bus.tri_valid = 1'b0;
        lo = y0; if (y1 < lo) lo = y1; if (y2 < lo) lo = y2; if (lo < 0) lo = 0;
        hi = y0; if (y1 > hi) hi = y1; if (y2 > hi) hi = y2; if (hi > SCR - 1) hi = SCR - 1;
        exp_count = (exp_count + 1) % 65536;
        for (int h = lo; h <= hi; h++) begin
            l.h = h; l.t = t; l.c = c; l.cyc = (h == lo) ? t_acc + 2 : -1;
            exp_lines.push_back(l);
        end
        d.cnt = exp_count;
        d.cyc = (lo > hi) ? t_acc + 2 : -1;
        exp_done.push_back(d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_done.size() != 0 || bus.busy !== 1'b0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_in_budget", (n < 3000), 1);
    endtask

    // Colorfill model: data_ready LAT cycles after color_en, dropped by reset.
    initial begin : colorfill_model
        int cnt;
        cnt = 0;
        bus.fill_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.fill_done = 1'b0;
            if (rst) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) bus.fill_done = 1'b1;
            end else if (bus.fill_en) cnt = LAT;
        end
    end

    initial begin : monitor
        line_t e;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 1'b0;
            end else begin
                if (bus.fill_en) begin
                    if (exp_lines.size() == 0) begin
                        chk("unexpected_fill_en_height", bus.fill_height, 16'hFFFF);
                    end else begin
                        e = exp_lines.pop_front();
                        chk("fill_height", bus.fill_height, e.h);
                        chk("fill_tri", bus.fill_tri, e.t);
                        chk("fill_color", bus.fill_color, e.c);
                        if (e.cyc >= 0) chk("first_fill_en_cycle", cyc, e.cyc);
                        pend = e;
                        pending = 1'b1;
                    end
                end else if (pending) begin
                    chk("held_height", bus.fill_height, pend.h);
                    chk("held_tri", bus.fill_tri, pend.t);
                    chk("held_color", bus.fill_color, pend.c);
                    if (bus.fill_done) pending = 1'b0;
                end
                if (bus.tri_done) begin
                    last_done_cyc = cyc;
                    if (exp_done.size() == 0) begin
                        chk("unexpected_tri_done", 1, 0);
                    end else begin
                        d = exp_done.pop_front();
                        chk("tri_count_at_done", bus.tri_count, d.cnt);
                        if (d.cyc >= 0) chk("tri_done_cycle", cyc, d.cyc);
                        chk("lines_before_done", exp_lines.size(), 0);
                    end
                    chk("busy_at_done", bus.busy, 1);
                end
            end
        end
    end

    task automatic wd_run(input int y0, input int y1, input bit do_clear, output int t_acc,
                          output int c_en, output int c_err, output int c_done, output int n_en,
                          output bit err_at_done);
        int n;
        wbus.tri_valid = 1'b1;
        wbus.tri_in    = mk_tri(y0, y1, y1);
        wbus.tri_color = 24'h0A0B0C;
        n = 0;
        while (wbus.tri_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        t_acc = cyc;
        @(posedge clk); #1;
        wbus.tri_valid = 1'b0;
        c_en = -1; c_err = -1; c_done = -1; n_en = 0; err_at_done = 1'b0;
        n = 0;
        while (c_done < 0 && n < 100) begin
            wbus.clear_err = do_clear && (c_en >= 0) && (cyc == c_en + 15);
            if (wbus.fill_en) begin
                n_en++;
                if (c_en < 0) c_en = cyc;
            end
            if (wbus.timeout_err && c_err < 0) c_err = cyc;
            if (wbus.tri_done) begin
                c_done = cyc;
                err_at_done = wbus.timeout_err;
            end
            @(posedge clk); #1;
            n++;
        end
        wbus.clear_err = 1'b0;
    endtask

    initial begin : guard
        #1000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int ta, tb2, c_en, c_err, c_done, n_en, n;
        bit err_done;
        rst = 1'b1;
        bus.tri_valid = 1'b0;  bus.tri_in = '0;  bus.tri_color = '0;  bus.clear_err = 1'b0;
        wbus.tri_valid = 1'b0; wbus.tri_in = '0; wbus.tri_color = '0; wbus.clear_err = 1'b0;
        wbus.fill_done = 1'b0;
        #12;
        check_reset("reset");
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;

        send(10, 12, 11, 24'h102030, ta);
        drain();
        chk("tri_count_after_first", bus.tri_count, 1);

        send(-5, -1, -3, 24'h0000FF, ta);
        drain();
        send(470, 500, 490, 24'hFF8000, ta);
        drain();
        send(100, 100, 100, 24'h00FF00, ta);
        drain();
        chk("tri_count_after_four", bus.tri_count, 4);

        send(30, 31, 30, 24'h111111, ta);
        send(40, 41, 40, 24'h222222, tb2);
        chk("b2b_accept_after_done", tb2, last_done_cyc + 1);
        drain();
        chk("tri_count_after_b2b", bus.tri_count, 6);

        wd_run(50, 50, 1'b0, ta, c_en, c_err, c_done, n_en, err_done);
        chk("wd_first_fill_en", c_en, ta + 2);
        chk("wd_err_rise", c_err, ta + 2 + 16);
        chk("wd_done_cycle", c_done, ta + 2 + 16);
        chk("wd_fill_en_count", n_en, 1);
        chk("wd_tri_count", wbus.tri_count, 1);

        wd_run(60, 61, 1'b1, ta, c_en, c_err, c_done, n_en, err_done);
        chk("wd2_done_cycle", c_done, ta + 2 + 16);
        chk("wd2_set_beats_clear", err_done, 1);
        chk("wd2_aborted_lines", n_en, 1);
        chk("wd2_tri_count", wbus.tri_count, 2);
        wbus.clear_err = 1'b1;
        @(posedge clk); #1;
        wbus.clear_err = 1'b0;
        chk("wd_clear_err", wbus.timeout_err, 0);

        send(200, 210, 205, 24'h333333, ta);
        n = 0;
        while (!pending && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_test_line_started", pending, 1);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset("async_rst");
        exp_lines.delete();
        exp_done.delete();
        exp_count = 0;
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        send(5, 6, 5, 24'h445566, ta);
        drain();
        chk("tri_count_after_rst", bus.tri_count, 1);

        chk("lines_left", exp_lines.size(), 0);
        chk("dones_left", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
